// File: rtl/pipe_pkg.sv
// Shared pipeline payload widths; stage users pass one of these as WIDTH.
package pipe_pkg;
  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 64;
  localparam int CTRL_W  = 1;
endpackage

// File: rtl/en_reg.sv
// Register with load enable and synchronous active-low reset to RESET_VAL.
module en_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q <= RESET_VAL;
    end else if (load) begin
      val_q <= d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/skid_stage_reg.sv
// Pipeline stage register with valid/ready on both sides and a one-entry skid
// buffer, so in_ready is register-derived and throughput stays at one per cycle.
module skid_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic [WIDTH-1:0] skid_d_q;
  logic             main_load, skid_load;
  logic             accept, pop;

  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign count     = {1'b0, main_v_q} + {1'b0, skid_v_q};

  assign accept = in_valid & in_ready;
  assign pop    = main_v_q & out_ready;

  always_comb begin
    main_v_d  = main_v_q;
    skid_v_d  = skid_v_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d_d  = in_data;
    if (flush) begin
      // Data registers keep their contents; only the valids are squashed.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept) begin
        main_load = 1'b1;
        main_v_d  = 1'b1;
      end
    end else if (!skid_v_q) begin
      if (pop) begin
        if (accept) begin
          main_load = 1'b1;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (accept) begin
        skid_load = 1'b1;
        skid_v_d  = 1'b1;
      end
    end else if (pop) begin
      main_load = 1'b1;
      main_d_d  = skid_d_q;
      skid_v_d  = 1'b0;
    end
  end

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main_d (
    .clk(clk), .reset(reset), .load(main_load), .d(main_d_d), .q(main_d_q)
  );

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid_d (
    .clk(clk), .reset(reset), .load(skid_load), .d(in_data), .q(skid_d_q)
  );

  en_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_main_v (
    .clk(clk), .reset(reset), .load(1'b1), .d(main_v_d), .q(main_v_q)
  );

  en_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_skid_v (
    .clk(clk), .reset(reset), .load(1'b1), .d(skid_v_d), .q(skid_v_q)
  );

endmodule

// File: tb/tb_skid_stage_reg.sv
// Scoreboard bench for skid_stage_reg: a reference FIFO of held items
// (capacity two) predicts every output; a negedge monitor pops on handshakes.
module tb_skid_stage_reg;

  localparam int             W    = 64;
  localparam logic [W-1:0]   RVAL = 64'hDEAD;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] held[$];
  logic         model_in_ready = 1'b1;
  logic [W-1:0] seq_val;

  skid_stage_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic fl, input logic iv,
                               input logic [W-1:0] data, input logic ordy);
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: items accepted while fewer than two are held; reset and
  // flush discard everything still held after this cycle's delivery.
  always @(posedge clk) begin
    if (!reset || flush) begin
      held.delete();
    end else if (in_valid && model_in_ready) begin
      held.push_back(in_data);
    end
  end

  // Monitor: compare status against the model, then pop on a handshake.
  always @(negedge clk) begin
    logic [W-1:0] exp_d;
    checkOutput("out_valid", W'(out_valid), W'(held.size() > 0));
    checkOutput("in_ready",  W'(in_ready),  W'(held.size() < 2));
    checkOutput("count",     W'(count),     W'(held.size()));
    checkOutput("invariant", W'(count == 2'd2 && !out_valid), '0);
    model_in_ready = (held.size() < 2);
    if (out_valid && out_ready) begin
      if (held.size() == 0) begin
        checkOutput("unexpected_out", out_data, '0);
        errors++;
      end else begin
        exp_d = held.pop_front();
        checkOutput("out_data", out_data, exp_d);
      end
    end
  end

  initial begin
    // Reset with traffic present.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h55, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h55, 1'b1);
    checkOutput("rst_out_valid", W'(out_valid), '0);
    checkOutput("rst_in_ready",  W'(in_ready),  W'(1));
    checkOutput("rst_count",     W'(count),     '0);
    checkOutput("rst_out_data",  out_data,      RVAL);

    // Streaming 1..4 with downstream always ready.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, W'(i), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Stall: A, B, C offered with out_ready low, then release.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hA, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hB, 1'b0);
    checkOutput("stall_count",    W'(count),    W'(2));
    checkOutput("stall_in_ready", W'(in_ready), '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hC, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hC, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hC, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush while A and B are held and C is offered.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hA, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hB, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'hC, 1'b0);
    checkOutput("flush_count",    W'(count),    '0);
    checkOutput("flush_in_ready", W'(in_ready), W'(1));

    // Pop and accept in the same cycle with the skid empty.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h1111, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h2222, 1'b1);
    checkOutput("popacc_data",  out_data,  64'h2222);
    checkOutput("popacc_count", W'(count), W'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Reset mid-operation with flush and an offered item.
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h77, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h88, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h99, 1'b1);
    checkOutput("midrst_count",    W'(count), '0);
    checkOutput("midrst_out_data", out_data,  RVAL);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 64'h100 + W'(i), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Randomised traffic with occasional flush and reset.
    seq_val = 64'h1000;
    for (int i = 0; i < 400; i++) begin
      seq_val = seq_val + {32'($urandom), 32'($urandom_range(1, 255))};
      applyStimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 5),
                    ($urandom_range(0, 99) < 70), seq_val,
                    ($urandom_range(0, 99) < 65));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
